rr_mux_arbiter: RTL and testbench
=================================

Name: rr_mux_arbiter

Overview:
Round-robin arbiter that sits directly upstream of the 4:1 mux and drives its 2-bit select. Four requesters compete for the shared mux path. The block grants one requester at a time, holds the grant until the requester signals done, drops its request, or exceeds a hold limit. It outputs the binary select for the mux plus a one-hot grant vector, using the same A/B to F3..F0 decode as the mux one-hot decoder.

Parameters:
MAX_HOLD, 16, maximum cycles a grant may be held; 0 = unlimited
HOLD_W, 8, width of the hold counter; must hold MAX_HOLD (checked at elaboration)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
req  input  4  request per channel; bit i = mux input i
done  input  1  current grantee finished; sampled only while gnt_valid=1
sel  output  2  binary select to mux; registered
grant  output  4  one-hot grant; equals decode(sel) when gnt_valid=1, else 4'b0000
gnt_valid  output  1  a grant is active; sel is meaningful
timeout  output  1  one-cycle pulse: grant revoked by hold limit

Behaviour:
- Reset (async assert, sync-deasserted upstream): sel=2'b00, grant=4'b0000, gnt_valid=0, timeout=0, state=IDLE, priority pointer ptr=2'd0, hold counter=0. Asserting rst_n mid-grant clears everything immediately.
- Search: find the first i with req[i]=1, scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4). On every grant, ptr <= granted index + 1 (mod 4). The just-served channel is therefore lowest priority next round.
- States: IDLE, GRANT.
- IDLE:
  - If any req bit is set, the next edge loads sel=picked index, grant=onehot, gnt_valid=1, hold counter=1, and the state moves to GRANT.
  - Latency from req rise to gnt_valid is 1 cycle.
  - With no request, the block stays in IDLE. sel holds its last value; grant=0.
- GRANT: release is evaluated each cycle on three conditions:
  - (a) done=1
  - (b) req[sel]=0 (requester withdrew)
  - (c) MAX_HOLD!=0 and hold counter==MAX_HOLD
- On release:
  - The search runs on the current req with ptr already advanced past sel.
  - If a candidate exists, it is granted on the next edge back-to-back, with no idle cycle. The same channel may be re-granted if it is the only requester; the counter restarts at 1.
  - If no candidate exists, the block returns to IDLE with gnt_valid=0 and grant=0.
- No release: the hold counter increments, saturating at its max value.
- timeout: asserted for exactly the cycle after a release caused solely by (c). If done or withdrawal coincides with the limit, it is a normal release and timeout stays 0.
- done while gnt_valid=0 is ignored.
- req changes on non-granted channels never disturb an active grant.
- sel and grant change only on clock edges; no combinational path from req to outputs.

Decomposition:
- Shared package mux_pkg:
  - N_CH=4, SEL_W=2
  - state enum {IDLE, GRANT}
  - function onehot(sel) implementing the A B -> F3..F0 decode table
- One natural sub-module, rr_pick: combinational, inputs req[3:0] and ptr[1:0], outputs found and idx[1:0]. The top holds state, counters, and registers.

Test Plan:
- Reset with req=4'b1111 held -> all outputs zero during reset; 1 cycle after release gnt_valid=1, sel=0, grant=4'b0001.
- req=4'b1111, done pulsed every 3rd cycle of each grant -> grant order 0,1,2,3,0 with no idle cycle between grants.
- MAX_HOLD=4, req=4'b0100 only, done=0 -> sel=2 held 4 cycles, timeout pulses once, channel 2 re-granted immediately; repeats every 4 cycles.
- Channel 1 granted, req[1] drops while req[3] high -> next cycle sel=3, grant=4'b1000, timeout=0.
- done and hold limit coincide on cycle 16 -> release with timeout=0; done asserted while idle -> no state change.
- rst_n asserted mid-grant on channel 2 -> outputs clear immediately; after release with req=4'b1111, the first grant goes to channel 0 (ptr reset).

Source files
------------

// File: rtl/rr_mux_arbiter_pkg.sv
// Shared definitions for the 4:1 mux path: channel count, select width,
// arbiter state encoding and the A/B -> F3..F0 one-hot decode.
package mux_pkg;

    localparam int N_CH  = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // A is sel[1], B is sel[0]; F0 is active for AB=00.
    function automatic logic [N_CH-1:0] onehot(input logic [SEL_W-1:0] sel);
        logic [N_CH-1:0] f;
        case (sel)
            2'b00:   f = 4'b0001;
            2'b01:   f = 4'b0010;
            2'b10:   f = 4'b0100;
            default: f = 4'b1000;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/rr_mux_arbiter_rr_pick.sv
// Rotating priority search: first requester at or after ptr, wrapping mod 4.
// Purely combinational.
module rr_pick
    import mux_pkg::*;
(
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic             found,
    output logic [SEL_W-1:0] idx
);

    // Scan offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves
        // it unassigned; otherwise synthesis infers a latch.
        found = 1'b0;
        idx   = ptr;
        for (int o = N_CH - 1; o >= 0; o--) begin
            if (req[ptr + SEL_W'(o)]) begin
                found = 1'b1;
                idx   = ptr + SEL_W'(o);
            end
        end
    end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter driving the registered 2-bit select of the shared 4:1 mux,
// with done/withdraw/hold-limit release and a one-cycle timeout pulse.
module rr_mux_arbiter
    import mux_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int HOLD_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_CH-1:0]  req,
    input  logic             done,
    output logic [SEL_W-1:0] sel,
    output logic [N_CH-1:0]  grant,
    output logic             gnt_valid,
    output logic             timeout
);

    if (MAX_HOLD < 0 || HOLD_W < 1 || HOLD_W > 30 || MAX_HOLD >= (1 << HOLD_W)) begin : g_hold_w_check
        $fatal(1, "rr_mux_arbiter: HOLD_W=%0d cannot represent MAX_HOLD=%0d", HOLD_W, MAX_HOLD);
    end

    localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_ONE   = HOLD_W'(1);

    state_t            state_q, state_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [N_CH-1:0]   grant_q, grant_d;
    logic              valid_q, valid_d;
    logic              timeout_q, timeout_d;
    logic [SEL_W-1:0]  ptr_q, ptr_d;
    logic [HOLD_W-1:0] hold_q, hold_d;

    logic              pick_found;
    logic [SEL_W-1:0]  pick_idx;
    logic              at_limit;
    logic              withdrawn;
    logic              release_grant;

    // ptr already sits one past the current grantee, so the same search
    // serves both the idle pick and the back-to-back pick on release.
    rr_pick u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign at_limit      = (MAX_HOLD != 0) && (hold_q == HOLD_LIMIT);
    assign withdrawn     = !req[sel_q];
    assign release_grant = done || withdrawn || at_limit;

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        grant_d   = grant_q;
        valid_d   = valid_q;
        timeout_d = 1'b0;
        ptr_d     = ptr_q;
        hold_d    = hold_q;

        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = GRANT;
                    sel_d   = pick_idx;
                    grant_d = onehot(pick_idx);
                    valid_d = 1'b1;
                    ptr_d   = pick_idx + SEL_W'(1);
                    hold_d  = HOLD_ONE;
                end
            end

            GRANT: begin
                if (release_grant) begin
                    // Only a pure hold-limit revocation is reported as a timeout.
                    timeout_d = at_limit && !done && !withdrawn;
                    if (pick_found) begin
                        sel_d   = pick_idx;
                        grant_d = onehot(pick_idx);
                        ptr_d   = pick_idx + SEL_W'(1);
                        hold_d  = HOLD_ONE;
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                        valid_d = 1'b0;
                    end
                end else if (hold_q != '1) begin
                    hold_d = hold_q + HOLD_ONE;
                end
            end

            default: begin
                state_d = IDLE;
                grant_d = '0;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            grant_q   <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            ptr_q     <= '0;
            hold_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling the
            // pre-edge values, independent of statement order.
            state_q   <= state_d;
            sel_q     <= sel_d;
            grant_q   <= grant_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
        end
    end

    assign sel       = sel_q;
    assign grant     = grant_q;
    assign gnt_valid = valid_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed plus randomized bench for rr_mux_arbiter; two instances (hold
// limits 16 and 4) share stimulus and are compared to a behavioural model.
module tb_rr_mux_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = 4'b0000;
    logic       done = 1'b0;

    logic [1:0] sel16, sel4;
    logic [3:0] grant16, grant4;
    logic       valid16, valid4;
    logic       to16, to4;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    rr_mux_arbiter #(.MAX_HOLD(16), .HOLD_W(8)) dut16 (
        .clk(clk), .rst_n(rst_n), .req(req), .done(done),
        .sel(sel16), .grant(grant16), .gnt_valid(valid16), .timeout(to16)
    );

    rr_mux_arbiter #(.MAX_HOLD(4), .HOLD_W(8)) dut4 (
        .clk(clk), .rst_n(rst_n), .req(req), .done(done),
        .sel(sel4), .grant(grant4), .gnt_valid(valid4), .timeout(to4)
    );

    // Model: who owns the mux (-1 = nobody), how long, and whose turn is next.
    int m_max   [2] = '{16, 4};
    int m_owner [2];
    int m_hold  [2];
    int m_ptr   [2];
    int m_sel   [2];
    bit m_to    [2];
    int m_to_cnt[2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [3:0] r, input int p);
        for (int o = 0; o < 4; o++) begin
            if (r[(p + o) % 4]) return (p + o) % 4;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_owner[k] = -1;
            m_hold[k]  = 0;
            m_ptr[k]   = 0;
            m_sel[k]   = 0;
            m_to[k]    = 1'b0;
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            int  p;
            bit  lim, wd, rel;
            m_to[k] = 1'b0;
            rel = 1'b1;
            if (m_owner[k] >= 0) begin
                lim = (m_max[k] != 0) && (m_hold[k] == m_max[k]);
                wd  = !req[m_owner[k]];
                rel = done || wd || lim;
                if (rel) m_to[k] = lim && !done && !wd;
            end
            if (rel) begin
                p = pick(req, m_ptr[k]);
                if (p >= 0) begin
                    m_owner[k] = p;
                    m_sel[k]   = p;
                    m_hold[k]  = 1;
                    m_ptr[k]   = (p + 1) % 4;
                end else begin
                    m_owner[k] = -1;
                end
            end else if (m_hold[k] < 255) begin
                m_hold[k]++;
            end
            if (m_to[k]) m_to_cnt[k]++;
        end
    endtask

    task automatic check_outputs();
        for (int k = 0; k < 2; k++) begin
            logic [1:0] s;
            logic [3:0] g, eg;
            logic       v, t;
            s = (k == 0) ? sel16   : sel4;
            g = (k == 0) ? grant16 : grant4;
            v = (k == 0) ? valid16 : valid4;
            t = (k == 0) ? to16    : to4;
            eg = (m_owner[k] >= 0) ? (4'b0001 << m_owner[k]) : 4'b0000;
            check($sformatf("sel[mh%0d]", m_max[k]),       32'(s), 32'(m_sel[k]));
            check($sformatf("grant[mh%0d]", m_max[k]),     32'(g), 32'(eg));
            check($sformatf("gnt_valid[mh%0d]", m_max[k]), 32'(v), 32'(m_owner[k] >= 0));
            check($sformatf("timeout[mh%0d]", m_max[k]),   32'(t), 32'(m_to[k]));
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        if (rst_n) model_step();
        else       model_reset();
        #1;
        check_outputs();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_sel"},   32'({sel16, sel4}),     32'h0);
        check({tag, "_grant"}, 32'({grant16, grant4}), 32'h0);
        check({tag, "_valid"}, 32'({valid16, valid4}), 32'h0);
        check({tag, "_to"},    32'({to16, to4}),       32'h0);
    endtask

    initial begin
        int order[$];
        int exp_order[5] = '{0, 1, 2, 3, 0};
        int to4_seen;
        bit hit;
        bit was_done;

        m_to_cnt = '{0, 0};
        model_reset();

        // Reset held with all channels requesting.
        rst_n = 1'b0;
        req   = 4'b1111;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("in_reset");
        @(negedge clk);
        rst_n = 1'b1;
        cycle();
        check("first_valid", 32'(valid16), 32'd1);
        check("first_sel",   32'(sel16),   32'd0);
        check("first_grant", 32'(grant16), 32'b0001);

        // Round robin with done on the third cycle of every grant.
        order.push_back(int'(sel16));
        for (int c = 0; c < 12; c++) begin
            done = (m_hold[0] == 3);
            cycle();
            check("rr_no_idle", 32'(valid16), 32'd1);
            if (int'(sel16) != order[$]) order.push_back(int'(sel16));
        end
        done = 1'b0;
        check("rr_order_len", 32'(order.size()), 32'd5);
        for (int i = 0; i < 5 && i < order.size(); i++)
            check($sformatf("rr_order[%0d]", i), 32'(order[i]), 32'(exp_order[i]));

        // Only channel 2: hold-limit re-grants; done lands on the 16-limit cycle.
        req = 4'b0100;
        to4_seen = 0;
        hit = 1'b0;
        m_to_cnt[1] = 0;
        for (int c = 0; c < 60 && !hit; c++) begin
            done = (m_owner[0] == 2) && (m_hold[0] == 16);
            was_done = done;
            cycle();
            if (to4) to4_seen++;
            if (was_done) begin
                check("coincide_timeout", 32'(to16),    32'd0);
                check("coincide_sel",     32'(sel16),   32'd2);
                check("coincide_valid",   32'(valid16), 32'd1);
                hit = 1'b1;
            end
        end
        done = 1'b0;
        check("coincide_reached", 32'(hit), 32'd1);
        check("to4_pulses", 32'(to4_seen), 32'(m_to_cnt[1]));
        check("to4_pulses_3plus", 32'(to4_seen >= 3), 32'd1);

        // Channel 1 withdraws while channel 3 waits.
        req = 4'b0010;
        for (int c = 0; c < 10 && m_owner[0] != 1; c++) cycle();
        check("reach_ch1", 32'(sel16), 32'd1);
        req = 4'b1010;
        cycle();
        req = 4'b1000;
        cycle();
        check("withdraw_sel",   32'(sel16),   32'd3);
        check("withdraw_grant", 32'(grant16), 32'b1000);
        check("withdraw_to",    32'(to16),    32'd0);

        // Idle, then done with no grant is ignored.
        req = 4'b0000;
        cycle();
        done = 1'b1;
        repeat (3) cycle();
        done = 1'b0;
        check("idle_done_valid", 32'(valid16), 32'd0);
        check("idle_sel_hold",   32'(sel16),   32'd3);

        // Reset in the middle of a channel-2 grant.
        req = 4'b0100;
        for (int c = 0; c < 10 && m_owner[0] != 2; c++) cycle();
        cycle();
        check("pre_reset_sel", 32'(sel16), 32'd2);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all_zero("async_reset");
        req = 4'b1111;
        cycle();
        cycle();
        @(negedge clk);
        rst_n = 1'b1;
        cycle();
        check("post_reset_sel",   32'(sel16),   32'd0);
        check("post_reset_grant", 32'(grant16), 32'b0001);

        // Randomized traffic against the model.
        for (int c = 0; c < 500; c++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
            done = ($urandom_range(0, 4) == 0);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Hard stop if the sequence above ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, required finish before 200000");
        $fatal(1, "watchdog");
    end

endmodule
